mdu_unit: RTL and testbench

- Multiply/divide unit in the EX stage; executes the 4-bit MDU operation code emitted by the decoder (DIV, DIVU, MUL, MULT, MULTU, MFHI, MFLO, MTHI, MTLO).
- Owns the architectural HI/LO registers.
- Multi-cycle operations assert busy_o so the pipeline interlocks.
- result_o feeds the EX result mux (result select 4) for MUL/MFHI/MFLO.

---
 rtl/mdu_unit_pkg.sv | 38 +++
 rtl/mdu_divider.sv | 76 +++++++
 rtl/mdu_unit.sv | 168 ++++++++++++++++
 tb/tb_mdu_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_unit_pkg : MDU op-codes, FSM state encoding and a sign helper     |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package mdu_unit_pkg;

    localparam int MDU_W = 32;

    // Shared with the decoder; codes 10-15 decode as no operation.
    typedef enum logic [3:0] {
        MDU_OP_NONE  = 4'd0,
        MDU_OP_DIV   = 4'd1,
        MDU_OP_DIVU  = 4'd2,
        MDU_OP_MUL   = 4'd3,
        MDU_OP_MULT  = 4'd4,
        MDU_OP_MULTU = 4'd5,
        MDU_OP_MFHI  = 4'd6,
        MDU_OP_MFLO  = 4'd7,
        MDU_OP_MTHI  = 4'd8,
        MDU_OP_MTLO  = 4'd9
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    function automatic logic [MDU_W-1:0] cond_neg(input logic [MDU_W-1:0] v,
                                                   input logic neg);
        return neg ? (~v + {{(MDU_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_divider : unsigned restoring divider, one quotient bit per cycle  |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module mdu_divider #(
    parameter int DATA_W    = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_STEPS + 1);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dsr_q;
    logic [CNT_W-1:0]  count_q;
    logic              done_q;

    logic [DATA_W-1:0] src_rem;
    logic [DATA_W-1:0] src_quo;
    logic [DATA_W-1:0] src_dsr;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic [DATA_W-1:0] next_rem;
    logic [DATA_W-1:0] next_quo;

    // The load cycle already performs the first step, so the last step lands
    // one cycle earlier and the caller sees done right after DIV_STEPS edges.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        src_dsr  = start ? divisor : dsr_q;
        shifted  = {src_rem, src_quo[DATA_W-1]};
        diff     = shifted - {1'b0, src_dsr};
        ge       = (shifted >= {1'b0, src_dsr});
        next_rem = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        next_quo = {src_quo[DATA_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else if (start) begin
            rem_q   <= next_rem;
            quo_q   <= next_quo;
            dsr_q   <= divisor;
            count_q <= CNT_W'(DIV_STEPS - 1);
            done_q  <= (DIV_STEPS == 1);
        end else if (count_q != '0) begin
            rem_q   <= next_rem;
            quo_q   <= next_quo;
            count_q <= count_q - 1'b1;
            done_q  <= (count_q == CNT_W'(1));
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_unit : EX-stage multiply/divide unit owning the HI/LO registers   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        mdu_op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    mdu_state_e        state;
    mdu_op_e           op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] res_q;

    mdu_op_e           op_in;
    logic              is_start;
    logic              is_div_in;
    logic              accept;
    logic              div_start;
    logic              div_signed_in;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dvs_mag;
    logic              div_done;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;

    logic              mul_signed;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;

    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;

    assign op_in     = mdu_op_e'(mdu_op_i);
    assign is_start  = (op_in inside {MDU_OP_DIV, MDU_OP_DIVU, MDU_OP_MUL,
                                      MDU_OP_MULT, MDU_OP_MULTU});
    assign is_div_in = (op_in == MDU_OP_DIV) || (op_in == MDU_OP_DIVU);
    assign accept    = (state == ST_IDLE) && is_start && !flush_i;
    assign busy_o    = accept || (state inside {ST_MUL, ST_DIV, ST_FIX});

    // The divider sees magnitudes straight from the ports so it can start in
    // the accept cycle; signs are restored from the latched operands in FIX.
    assign div_start     = accept && is_div_in;
    assign div_signed_in = (op_in == MDU_OP_DIV);
    assign dvd_mag       = cond_neg(rs_i, div_signed_in && rs_i[DATA_W-1]);
    assign dvs_mag       = cond_neg(rt_i, div_signed_in && rt_i[DATA_W-1]);

    mdu_divider #(
        .DATA_W    (DATA_W),
        .DIV_STEPS (DIV_STEPS)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign mul_signed = (op_q != MDU_OP_MULTU);
    assign a_ext      = {{DATA_W{mul_signed & a_q[DATA_W-1]}}, a_q};
    assign b_ext      = {{DATA_W{mul_signed & b_q[DATA_W-1]}}, b_q};
    assign prod       = a_ext * b_ext;

    // 0x80000000 / -1 falls out naturally: both signs negative, so the
    // quotient magnitude 0x80000000 is kept as-is and the remainder is 0.
    always_comb begin
        neg_q = (op_q == MDU_OP_DIV) && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        neg_r = (op_q == MDU_OP_DIV) && a_q[DATA_W-1];
        q_fix = cond_neg(div_quo, neg_q);
        r_fix = cond_neg(div_rem, neg_r);
        if (b_q == '0) begin
            q_fix = '1;
            r_fix = a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= MDU_OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        a_q   <= rs_i;
                        b_q   <= rt_i;
                        state <= is_div_in ? ST_DIV : ST_MUL;
                    end else if (op_in == MDU_OP_MTHI) begin
                        hi_q <= rs_i;
                    end else if (op_in == MDU_OP_MTLO) begin
                        lo_q <= rs_i;
                    end
                end
                ST_MUL: begin
                    if (op_q == MDU_OP_MUL) begin
                        res_q <= prod[DATA_W-1:0];
                    end else begin
                        hi_q <= prod[2*DATA_W-1:DATA_W];
                        lo_q <= prod[DATA_W-1:0];
                    end
                    state <= ST_DONE;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    lo_q  <= q_fix;
                    hi_q  <= r_fix;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        result_o = res_q;
        if (op_in == MDU_OP_MFHI) begin
            result_o = hi_q;
        end else if (op_in == MDU_OP_MFLO) begin
            result_o = lo_q;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdu_unit : scoreboard bench for mdu_unit                           |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          busy_cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];

    // Reference architectural state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_res = '0;

    mdu_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdu_op_i (mdu_op),
        .rs_i     (rs),
        .rt_i     (rt),
        .stall_i  (stall),
        .flush_i  (flush),
        .busy_o   (busy),
        .result_o (result),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sb2, sp;
        logic [63:0] up;
        logic signed [31:0] sq, sr;
        sa = $signed(a);
        sb2 = $signed(b);
        sp = sa * sb2;
        up = {32'd0, a} * {32'd0, b};
        e.busy_cyc = 0;
        case (op)
            4'd4: begin m_hi = sp[63:32]; m_lo = sp[31:0]; e.busy_cyc = 2; end
            4'd5: begin m_hi = up[63:32]; m_lo = up[31:0]; e.busy_cyc = 2; end
            4'd3: begin m_res = sp[31:0]; e.busy_cyc = 2; end
            4'd1, 4'd2: begin
                e.busy_cyc = 34;
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a;
                end else if (op == 4'd1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else if (op == 4'd1) begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    m_lo = sq; m_hi = sr;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            4'd8: m_hi = a;
            4'd9: m_lo = a;
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        e.res = m_res;
        return e;
    endfunction

    // Issue one op, follow busy until it drops, then check against the scoreboard.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string nm);
        exp_t e;
        int cyc;
        bit ok;
        sb.push_back(model(op, a, b));
        @(posedge clk); #1;
        mdu_op = op; rs = a; rt = b;
        cyc = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
            cyc++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mdu_op = 4'd0;
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL %s timeout: busy never dropped", nm);
        end
        n_vec++;
        if (cyc !== e.busy_cyc) begin
            n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, cyc, e.busy_cyc);
        end
        n_vec++;
        if (hi !== e.hi) begin
            n_err++; $display("FAIL %s hi: got %h expected %h", nm, hi, e.hi);
        end
        n_vec++;
        if (lo !== e.lo) begin
            n_err++; $display("FAIL %s lo: got %h expected %h", nm, lo, e.lo);
        end
        n_vec++;
        if (result !== e.res) begin
            n_err++; $display("FAIL %s result: got %h expected %h", nm, result, e.res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, hi, lo, result} !== {1'b0, 96'd0}) begin
            n_err++;
            $display("FAIL reset: busy=%b hi=%h lo=%h result=%h expected all zero",
                     busy, hi, lo, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mult();
        run_op(4'd4, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
        run_op(4'd5, 32'hFFFF_FFFE, 32'd3, "multu_neg2x3");
        run_op(4'd4, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    endtask

    task automatic test_div();
        run_op(4'd1, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_op(4'd2, 32'd7, 32'd0, "divu_by_zero");
        run_op(4'd1, 32'hFFFF_FFF9, 32'd0, "div_by_zero");
        run_op(4'd1, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(4'd2, 32'hFFFF_FFFF, 32'd10, "divu_big");
        run_op(4'd1, 32'd100, 32'hFFFF_FFF9, "div_100_neg7");
    endtask

    task automatic test_mflo_during_div();
        exp_t e;
        int cyc;
        bit ok;
        sb.push_back(model(4'd1, 32'd100, 32'd7));
        @(posedge clk); #1;
        mdu_op = 4'd1; rs = 32'd100; rt = 32'd7;
        cyc = 0; ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
            cyc++;
            @(posedge clk); #1;
            if (cyc == 5) mdu_op = 4'd7;
        end
        e = sb.pop_front();
        n_vec++;
        if (!ok || cyc !== 34) begin
            n_err++; $display("FAIL mflo_stall busy_cycles: got %0d expected 34", cyc);
        end
        n_vec++;
        if (result !== e.lo) begin
            n_err++; $display("FAIL mflo_done result: got %h expected %h", result, e.lo);
        end
        @(posedge clk); #1;
        mdu_op = 4'd0;
        @(posedge clk); #1;
        mdu_op = 4'd6;
        @(negedge clk);
        n_vec++;
        if (result !== e.hi || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mfhi_idle: result=%h busy=%b expected result=%h busy=0",
                     result, busy, e.hi);
        end
        @(posedge clk); #1;
        mdu_op = 4'd0;
    endtask

    task automatic test_flush();
        int cyc;
        run_op(4'd8, 32'h11, 32'd0, "mthi");
        run_op(4'd9, 32'h22, 32'd0, "mtlo");
        @(posedge clk); #1;
        mdu_op = 4'd1; rs = 32'd100; rt = 32'd7;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) cyc++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        if (busy) cyc++;
        n_vec++;
        if (cyc !== 11) begin
            n_err++; $display("FAIL flush_pre busy_cycles: got %0d expected 11", cyc);
        end
        @(posedge clk); #1;
        flush = 1'b0; mdu_op = 4'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                n_err++;
                $display("FAIL flush_post c%0d: busy=%b hi=%h lo=%h expected busy=0 hi=%h lo=%h",
                         i, busy, hi, lo, m_hi, m_lo);
                break;
            end
        end
        // A flushed MTHI must not write.
        @(posedge clk); #1;
        mdu_op = 4'd8; rs = 32'hDEAD_BEEF; flush = 1'b1;
        @(posedge clk); #1;
        mdu_op = 4'd0; flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if (hi !== m_hi) begin
            n_err++; $display("FAIL flush_mthi: got hi=%h expected %h", hi, m_hi);
        end
    endtask

    task automatic test_stall_done();
        exp_t e;
        int cyc;
        sb.push_back(model(4'd3, 32'd6, 32'd7));
        @(posedge clk); #1;
        mdu_op = 4'd3; rs = 32'd6; rt = 32'd7; stall = 1'b1;
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        n_vec++;
        if (cyc !== e.busy_cyc) begin
            n_err++; $display("FAIL mul_stall busy_cycles: got %0d expected %0d", cyc, e.busy_cyc);
        end
        // DONE cycle plus two more with stall held: three stalled DONE cycles
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            if (busy !== 1'b0 || result !== e.res) begin
                n_err++;
                $display("FAIL stall_done c%0d: busy=%b result=%h expected busy=0 result=%h",
                         i, busy, result, e.res);
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || result !== e.res) begin
            n_err++;
            $display("FAIL stall_release: busy=%b result=%h expected busy=0 result=%h",
                     busy, result, e.res);
        end
        @(posedge clk); #1;
        mdu_op = 4'd0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || result !== e.res || hi !== e.hi || lo !== e.lo) begin
            n_err++;
            $display("FAIL mul_after: busy=%b result=%h hi=%h lo=%h expected 0 %h %h %h",
                     busy, result, hi, lo, e.res, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mflo_during_div();
        test_flush();
        test_stall_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
